mem_cycle_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of the 32K×12 core-memory emulation. Grants memory cycles to the CPU or to the data-break (DMA) channel, generates the `mem_start` / `mem_done_n` handshake, and holds address and data stable for the whole cycle. Supplies the restore data for read cycles, since the memory rewrites its location on every cycle. Also performs the data-break memory-increment operation.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 22 ++
 rtl/mem_cycle_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_cycle_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the core-memory cycle arbiter: opcodes, FSM states, default timeout.
package mem_arb_pkg;

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_INC = 2'd2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ARM  = 2'd1;
    localparam state_t ST_BUSY = 2'd2;
    localparam state_t ST_ACK  = 2'd3;

    localparam int TIMEOUT_DEFAULT = 200;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the CPU and data-break ports.
// MEM_ARB_RR_EN: round-robin on contention; otherwise fixed break-over-CPU priority.
module mem_arb_pick (
    input  logic cpu_req,
    input  logic brk_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_brk,
`endif
    output logic pick_brk,
    output logic pick_any
);

    assign pick_any = cpu_req | brk_req;

`ifdef MEM_ARB_RR_EN
    // On contention the port that did not win last time gets the cycle.
    assign pick_brk = brk_req & (~cpu_req | ~last_brk);
`else
    assign pick_brk = brk_req;
`endif

endmodule

// File: rtl/mem_cycle_arbiter.sv
// Memory-cycle sequencer and CPU/data-break arbiter for the core-memory emulation.
// MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_pick).
module mem_cycle_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              brk_req,
    input  logic [1:0]        brk_op,
    input  logic [ADDR_W-1:0] brk_addr,
    input  logic [DATA_W-1:0] brk_wdata,
    output logic              brk_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              ovf,
    output logic              grant_brk,
    output logic              busy,
    output logic              timeout_err,
    output logic              mem_start,
    input  logic              mem_done_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              pick_brk;
    logic              pick_any;
    logic              tmo_hit;

    mem_arb_pick u_pick (
        .cpu_req (cpu_req),
        .brk_req (brk_req),
`ifdef MEM_ARB_RR_EN
        .last_brk(grant_brk),
`endif
        .pick_brk(pick_brk),
        .pick_any(pick_any)
    );

    assign mem_start = (state == ST_ARM) || (state == ST_BUSY);
    assign busy      = (state != ST_IDLE);
    assign mem_addr  = addr_q;
    assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT_CYC));

    // Write-back word: the memory rewrites the location on every cycle.
    always_comb begin
        // NOTE: default first so every path assigns mem_data_in and no latch is inferred.
        mem_data_in = mem_data_out;
        case (op_q)
            OP_WR:   mem_data_in = wdata_q;
            OP_INC:  mem_data_in = mem_data_out + DATA_W'(1);
            default: mem_data_in = mem_data_out;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state       <= ST_IDLE;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            tmo_cnt     <= '0;
            rd_data     <= '0;
            ovf         <= 1'b0;
            grant_brk   <= 1'b0;
            timeout_err <= 1'b0;
            cpu_ack     <= 1'b0;
            brk_ack     <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            brk_ack <= 1'b0;
            tmo_cnt <= mem_start ? tmo_cnt + CNT_W'(1) : '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_brk <= pick_brk;
                        op_q      <= pick_brk ? brk_op    : cpu_op;
                        addr_q    <= pick_brk ? brk_addr  : cpu_addr;
                        wdata_q   <= pick_brk ? brk_wdata : cpu_wdata;
                        state     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    // Wait out the stale done left low by the previous cycle.
                    if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= ST_ACK;
                    end else if (mem_done_n) begin
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!mem_done_n) begin
                        rd_data <= mem_data_out;
                        if (op_q == OP_INC)
                            ovf <= &mem_data_out;
                        state <= ST_ACK;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    cpu_ack <= ~grant_brk;
                    brk_ack <= grant_brk;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cycle_arbiter.sv
// Self-checking bench for mem_cycle_arbiter with a behavioural core-memory model and scoreboard.
module tb_mem_cycle_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 12;
    localparam int TMO     = 200;
    localparam int MEM_LAT = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0, brk_req = 1'b0;
    logic [1:0]        cpu_op = '0, brk_op = '0;
    logic [ADDR_W-1:0] cpu_addr = '0, brk_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0, brk_wdata = '0;
    logic              cpu_ack, brk_ack;
    logic [DATA_W-1:0] rd_data;
    logic              ovf, grant_brk, busy, timeout_err, mem_start;
    logic              mem_done_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out = '0;

    always #5 clk = ~clk;

    mem_cycle_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .brk_req(brk_req), .brk_op(brk_op), .brk_addr(brk_addr), .brk_wdata(brk_wdata), .brk_ack(brk_ack),
        .rd_data(rd_data), .ovf(ovf), .grant_brk(grant_brk), .busy(busy), .timeout_err(timeout_err),
        .mem_start(mem_start), .mem_done_n(mem_done_n), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Core memory: data out early in the cycle, write-back and done at MEM_LAT.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic start_d = 1'b0, active = 1'b0, hang = 1'b0;
    int   mcnt = 0;

    always @(posedge clk) begin
        start_d <= mem_start;
        if (active && !mem_start) begin
            active     <= 1'b0;
            mem_done_n <= 1'b0;
        end else if (mem_start && !start_d) begin
            active <= 1'b1;
            mcnt   <= 1;
        end else if (active) begin
            mcnt <= mcnt + 1;
            if (mcnt == 2) begin
                mem_done_n   <= 1'b1;
                mem_data_out <= mem[mem_addr];
            end
            if (mcnt == MEM_LAT && !hang) begin
                mem[mem_addr] <= mem_data_in;
                mem_done_n    <= 1'b0;
                active        <= 1'b0;
            end
        end
    end

    typedef struct {
        logic              brk;
        logic [ADDR_W-1:0] addr;
        logic              chk_rd;
        logic [DATA_W-1:0] rd;
        logic              chk_ovf;
        logic              ovf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;
    int   rem_cpu = 0, rem_brk = 0;
    int   lat;
    logic [7:0] order;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic p_brk, input logic [1:0] p_op, input logic [ADDR_W-1:0] p_addr,
                         input logic [DATA_W-1:0] p_wd, input int p_count);
        if (p_brk) begin
            brk_req = 1'b1; brk_op = p_op; brk_addr = p_addr; brk_wdata = p_wd; rem_brk = p_count;
        end else begin
            cpu_req = 1'b1; cpu_op = p_op; cpu_addr = p_addr; cpu_wdata = p_wd; rem_cpu = p_count;
        end
    endtask

    task automatic push(input logic p_brk, input logic [ADDR_W-1:0] p_addr, input logic p_chk_rd,
                        input logic [DATA_W-1:0] p_rd, input logic p_chk_ovf, input logic p_ovf);
        exp_t e;
        e.brk = p_brk; e.addr = p_addr; e.chk_rd = p_chk_rd; e.rd = p_rd;
        e.chk_ovf = p_chk_ovf; e.ovf = p_ovf;
        sb.push_back(e);
    endtask

    // Waits for the next ack, compares it with the scoreboard head, releases the request when done.
    task automatic wait_ack(output int p_lat);
        exp_t e;
        int   n, st;
        bit   got, addr_ok;
        logic was_brk;
        n = 0; st = -1; got = 1'b0; addr_ok = 1'b1; p_lat = -1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        while (!got && n < 400) begin
            @(posedge clk); #1; n++;
            if (cpu_ack || brk_ack) got = 1'b1;
            else if (mem_start) begin
                if (st < 0) st = n;
                if (mem_addr !== e.addr) addr_ok = 1'b0;
            end
        end
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
            return;
        end
        p_lat = (st < 0) ? -1 : n - st;
        check("ack_port", {brk_ack, cpu_ack}, e.brk ? 2'b10 : 2'b01);
        check("grant_brk", grant_brk, e.brk);
        check("addr_stable", addr_ok, 1);
        check("start_gap", mem_start, 0);
        if (e.chk_rd)  check("rd_data", rd_data, e.rd);
        if (e.chk_ovf) check("ovf", ovf, e.ovf);
        was_brk = brk_ack;
        if (was_brk) begin
            rem_brk--;
            if (rem_brk <= 0) brk_req = 1'b0;
        end else begin
            rem_cpu--;
            if (rem_cpu <= 0) cpu_req = 1'b0;
        end
        @(posedge clk); #1;
        check("ack_width", was_brk ? brk_ack : cpu_ack, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_start", mem_start, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {cpu_ack, brk_ack}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_flags", {ovf, grant_brk, timeout_err}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_data_in", mem_data_in, mem_data_out);
        rst = 1'b0;

        // Write then read back, with request-to-ack latency.
        issue(1'b0, OP_WR, 15'o00100, 12'o5252, 1);
        push(1'b0, 15'o00100, 1'b0, '0, 1'b0, 1'b0);
        wait_ack(lat);
        check("mem_wr_100", mem[15'o00100], 12'o5252);
        issue(1'b0, OP_RD, 15'o00100, '0, 1);
        push(1'b0, 15'o00100, 1'b1, 12'o5252, 1'b0, 1'b0);
        wait_ack(lat);
        check("rd_latency", lat, MEM_LAT + 3);
        check("busy_idle", busy, 0);

        // Back-to-back reads restore the location.
        issue(1'b0, OP_RD, 15'o00100, '0, 2);
        push(1'b0, 15'o00100, 1'b1, 12'o5252, 1'b0, 1'b0);
        push(1'b0, 15'o00100, 1'b1, 12'o5252, 1'b0, 1'b0);
        wait_ack(lat);
        wait_ack(lat);
        check("restore_100", mem[15'o00100], 12'o5252);

        // Break increments: wrap and plain.
        issue(1'b0, OP_WR, 15'o00400, 12'o7777, 1);
        push(1'b0, 15'o00400, 1'b0, '0, 1'b0, 1'b0);
        wait_ack(lat);
        issue(1'b1, OP_INC, 15'o00400, '0, 1);
        push(1'b1, 15'o00400, 1'b1, 12'o7777, 1'b1, 1'b1);
        wait_ack(lat);
        check("inc_wrap_mem", mem[15'o00400], 12'o0000);
        issue(1'b0, OP_WR, 15'o00401, 12'o0017, 1);
        push(1'b0, 15'o00401, 1'b0, '0, 1'b1, 1'b1);
        wait_ack(lat);
        issue(1'b1, OP_INC, 15'o00401, '0, 1);
        push(1'b1, 15'o00401, 1'b1, 12'o0017, 1'b1, 1'b0);
        wait_ack(lat);
        check("inc_mem", mem[15'o00401], 12'o0020);

        // Opcode 3 behaves as a read; leaves the CPU as last grantee.
        issue(1'b0, 2'd3, 15'o00100, 12'o1111, 1);
        push(1'b0, 15'o00100, 1'b1, 12'o5252, 1'b1, 1'b0);
        wait_ack(lat);
        check("op3_restore", mem[15'o00100], 12'o5252);

        // Contention: both ports held for four cycles each (bit k set = break wins cycle k).
`ifdef MEM_ARB_RR_EN
        order = 8'b0101_0101;
`else
        order = 8'b0000_1111;
`endif
        issue(1'b1, OP_RD, 15'o00100, '0, 4);
        issue(1'b0, OP_RD, 15'o00401, '0, 4);
        for (int k = 0; k < 8; k++)
            push(order[k], order[k] ? 15'o00100 : 15'o00401, 1'b1,
                 order[k] ? 12'o5252 : 12'o0020, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            wait_ack(lat);
        check("arb_reqs_released", {cpu_req, brk_req}, 0);

        // Memory never completes: abort after the timeout, rd_data held.
        hang = 1'b1;
        issue(1'b0, OP_RD, 15'o00100, '0, 1);
        push(1'b0, 15'o00100, 1'b1, 12'o0020, 1'b0, 1'b0);
        wait_ack(lat);
        check("timeout_latency", lat, TMO + 2);
        check("timeout_err", timeout_err, 1);
        hang = 1'b0;
        issue(1'b0, OP_RD, 15'o00100, '0, 1);
        push(1'b0, 15'o00100, 1'b1, 12'o5252, 1'b0, 1'b0);
        wait_ack(lat);
        check("timeout_sticky", timeout_err, 1);

        // Reset in the middle of a write cycle.
        issue(1'b0, OP_WR, 15'o00500, 12'o1234, 1);
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", {busy, mem_start}, 2'b11);
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("rst_async_start", mem_start, 0);
        @(posedge clk); #1;
        check("rst_mid_outputs", {cpu_ack, brk_ack, ovf, grant_brk, busy, timeout_err}, 0);
        check("rst_mid_rd_addr", {rd_data, mem_addr}, 0);
        rst = 1'b0;
        issue(1'b0, OP_RD, 15'o00100, '0, 1);
        push(1'b0, 15'o00100, 1'b1, 12'o5252, 1'b0, 1'b0);
        wait_ack(lat);
        check("post_rst_latency", lat, MEM_LAT + 3);
        check("post_rst_restore", mem[15'o00100], 12'o5252);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
